comb_bench_driver: RTL and testbench

- Self-test driver and response compactor for the small generated combinational benchmark circuits (5-input / 17-output class).
- Sits on the opposite side of the DUT pins. It drives the DUT inputs x through every pattern in order and samples the DUT outputs f after a programmable settle time.
- Sampled responses are folded into a MISR signature, which is compared with a golden value so each generated circuit can be checked in silicon or in simulation.

---
 rtl/comb_bench_driver.sv | 114 +++++++++++
 tb/tb_comb_bench_driver.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/comb_bench_driver.sv
// rtl/comb_bench_driver.sv - exhaustive pattern driver and MISR response compactor
module comb_bench_driver #(
  parameter int              N_IN   = 5,
  parameter int              N_OUT  = 17,
  parameter int              SETTLE = 2,
  parameter logic [N_OUT-1:0] POLY  = 17'h00009,
  parameter logic [N_OUT-1:0] SEED  = 17'h00000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [N_OUT-1:0] golden_sig,
  input  logic [N_OUT-1:0] f_in,
  output logic [N_IN-1:0]  x_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [N_OUT-1:0] signature
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETTLE  = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [N_IN-1:0]  r_x;
  logic [N_OUT-1:0] r_sig;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [N_OUT-1:0] w_sig_next;

  // One MISR step: shift, fold the dropped MSB back through POLY, absorb f_in.
  assign w_sig_next = {r_sig[N_OUT-2:0], 1'b0} ^ (r_sig[N_OUT-1] ? POLY : '0) ^ f_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_x     <= '0;
      r_sig   <= SEED;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_x     <= '0;
            r_sig   <= SEED;
            r_cnt   <= '0;
            r_pass  <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (abort) begin
            r_state <= S_IDLE;
            r_x     <= '0;
            r_cnt   <= '0;
            r_pass  <= 1'b0;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CNT_LAST) r_state <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          if (abort) begin
            r_state <= S_IDLE;
            r_x     <= '0;
            r_cnt   <= '0;
            r_pass  <= 1'b0;
            r_busy  <= 1'b0;
          end else begin
            r_sig <= w_sig_next;
            if (&r_x) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_x     <= r_x + 1'b1;
              r_cnt   <= '0;
              r_state <= S_SETTLE;
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_pass  <= (r_sig == golden_sig);
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign x_out     = r_x;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign signature = r_sig;

endmodule

// File: tb/tb_comb_bench_driver.sv
// tb/tb_comb_bench_driver.sv - scoreboard bench for comb_bench_driver
module tb_comb_bench_driver;

  logic        clk = 1'b0;
  logic        rst_n, start, abort;
  logic [16:0] golden_sig, f_in, signature;
  logic [4:0]  x_out;
  logic        busy, done, pass;

  logic        start2;
  logic [2:0]  golden2, sig2;
  logic [1:0]  x2;
  logic        busy2, done2, pass2;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic        f_mode, f_fault;
  int unsigned f_key;

  typedef struct {
    logic [16:0] sig;
    logic        pass;
    int          done_cyc;
  } exp_t;
  exp_t exp_q[$];

  comb_bench_driver dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .golden_sig(golden_sig), .f_in(f_in), .x_out(x_out),
    .busy(busy), .done(done), .pass(pass), .signature(signature)
  );

  comb_bench_driver #(.N_IN(2), .N_OUT(3), .SETTLE(1), .POLY(3'b011), .SEED(3'b000)) dut_small (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(1'b0),
    .golden_sig(golden2), .f_in({1'b0, x2}), .x_out(x2),
    .busy(busy2), .done(done2), .pass(pass2), .signature(sig2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [16:0] bench_f(int unsigned x, int unsigned key);
    int unsigned t;
    t = (x * 32'd2654435761) ^ key;
    t = t ^ (t >> 13);
    return t[16:0];
  endfunction

  // Reference MISR: the signature as an integer polynomial, one step per pattern.
  function automatic logic [16:0] model_sig(int unsigned key, int npat, logic mode, logic fault);
    int unsigned s = 0;
    int unsigned f;
    for (int p = 0; p < npat; p++) begin
      f = mode ? 32'(bench_f(p, key)) : 0;
      if (fault && p == 13) f = f ^ 1;
      s = ((s * 2) % 131072) ^ ((s >= 65536) ? 9 : 0) ^ f;
    end
    return s[16:0];
  endfunction

  always_comb begin
    f_in = '0;
    if (f_mode) f_in = bench_f(32'(x_out), f_key) ^ {16'd0, (f_fault && x_out == 5'd13)};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  logic pend = 1'b0;
  logic pend_pass;
  always @(negedge clk) begin
    exp_t e;
    if (pend) begin
      chk("pass_after_done", 32'(pass), 32'(pend_pass));
      pend = 1'b0;
    end
    if (done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'(done), 0);
      end else begin
        e = exp_q.pop_front();
        chk("final_signature", 32'(signature), 32'(e.sig));
        chk("done_cycle", cyc, e.done_cyc);
        pend = 1'b1;
        pend_pass = e.pass;
      end
    end
  end

  task automatic run_main(input logic mode, input logic fault, input int unsigned key,
                          input logic bad_golden, input logic restart, input logic with_abort);
    exp_t e;
    logic [16:0] good;
    int bcnt = 0;
    logic got = 1'b0;
    @(negedge clk);
    f_mode = mode; f_fault = fault; f_key = key;
    good = model_sig(key, 32, mode, 1'b0);
    golden_sig = bad_golden ? (good ^ (17'd1 << $urandom_range(0, 16))) : good;
    e.sig = model_sig(key, 32, mode, fault);
    e.pass = (e.sig == golden_sig);
    e.done_cyc = cyc + 97;
    exp_q.push_back(e);
    start = 1'b1;
    abort = with_abort;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      if (done) got = 1'b1;
      else begin
        if (busy) begin
          chk("x_out_step", 32'(x_out), bcnt / 3);
          bcnt++;
        end
        start = (restart && bcnt == 10);
        @(negedge clk);
      end
    end
    start = 1'b0;
    if (!got) begin
      chk("done_timeout", 0, 1);
      exp_q.delete();
    end
    chk("busy_cycles", bcnt, 96);
    repeat (3) @(negedge clk);
  endtask

  task automatic run_small(input logic [2:0] gold, input logic exp_pass);
    int c;
    logic got = 1'b0;
    @(negedge clk);
    golden2 = gold;
    c = cyc;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      if (done2) got = 1'b1;
      else @(negedge clk);
    end
    chk("small_done_seen", 32'(got), 1);
    chk("small_done_cycle", cyc, c + 9);
    chk("small_signature", 32'(sig2), 32'h3);
    @(negedge clk);
    chk("small_pass", 32'(pass2), 32'(exp_pass));
  endtask

  initial begin
    int c;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; start2 = 1'b0;
    golden_sig = '0; golden2 = '0;
    f_mode = 1'b0; f_fault = 1'b0; f_key = 0;
    repeat (3) @(negedge clk);
    chk("rst_x_out", 32'(x_out), 0);
    chk("rst_signature", 32'(signature), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_pass", 32'(pass), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_main(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    run_main(1'b1, 1'b0, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
    run_main(1'b1, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
    for (int r = 0; r < 4; r++)
      run_main(1'b1, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    run_main(1'b1, 1'b0, $urandom, 1'b0, 1'b1, 1'b0);
    run_main(1'b1, 1'b0, $urandom, 1'b0, 1'b0, 1'b1);

    run_small(3'b011, 1'b1);
    run_small(3'b010, 1'b0);

    // Abort during pattern 13's settle: thirteen patterns have been absorbed.
    @(negedge clk);
    f_mode = 1'b1; f_fault = 1'b0; f_key = 32'hcafe_f00d;
    c = cyc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < c + 40) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_x_out", 32'(x_out), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_pass", 32'(pass), 0);
    chk("abort_partial_sig", 32'(signature), 32'(model_sig(32'hcafe_f00d, 13, 1'b1, 1'b0)));
    repeat (120) @(negedge clk);
    chk("abort_stays_idle", 32'(busy), 0);
    run_main(1'b1, 1'b0, 32'hcafe_f00d, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    c = cyc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < c + 50) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_x_out", 32'(x_out), 0);
    chk("async_rst_busy", 32'(busy), 0);
    chk("async_rst_sig", 32'(signature), 0);
    chk("async_rst_done", 32'(done), 0);
    chk("async_rst_pass", 32'(pass), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (120) @(negedge clk);
    chk("post_rst_idle_busy", 32'(busy), 0);
    chk("post_rst_idle_x", 32'(x_out), 0);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
